dual_port_burst_ram: RTL and testbench
======================================

DUAL_PORT_BURST_RAM -- requirements
Module: dual_port_burst_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter BLEN_W, default 6, burst-length field width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have, per port p in {0,1}: port_en_p in 1, wr_en_p in 1, burst_en_p in 1, burst_len_p in BLEN_W, addr_in_p in ADDR_W, data_in_p in DATA_W.
REQ-007 SHALL have, per port p: data_out_p out DATA_W (read data), busy_p out 1 (burst/BIST in progress), burst_done_p out 1 (one-cycle pulse).
REQ-008 SHALL have collision out 1 (same-address conflict pulse), bist_start in 1, bist_done out 1, ram_passed out 1.

Function
REQ-009 Single access: port_en_p=1, burst_en_p=0, busy_p=0 -> at edge, write mem[addr_in_p]<=data_in_p if wr_en_p, else data_out_p<=mem[addr_in_p]; read latency 1 cycle.
REQ-010 data_out_p SHALL hold its last value when no read occurs on port p.
REQ-011 Burst start: port_en_p=1, burst_en_p=1, busy_p=0, burst_len_p>=1 -> beat 0 at addr_in_p on that edge; direction latched from wr_en_p; busy_p=1 after that edge if burst_len_p>=2.
REQ-012 Per-port FSM states IDLE, BURST; IDLE->BURST on burst start with len>=2; BURST->IDLE after beat len-1 or on abort.
REQ-013 Beat k SHALL access (start_addr + k) mod DEPTH; wrap from DEPTH-1 to 0 is silent.
REQ-014 Write bursts SHALL take data_in_p as presented at each beat edge; read bursts deliver one word per cycle, 1 cycle after each beat.
REQ-015 While busy_p=1, addr_in_p, wr_en_p, burst_en_p, burst_len_p SHALL be ignored.
REQ-016 burst_done_p SHALL pulse for exactly one cycle, the cycle after the final beat edge (aligned with last read word); len=1 bursts pulse it without asserting busy_p.
REQ-017 burst_len_p=0 with burst_en_p=1 SHALL perform no access and no pulse.
REQ-018 port_en_p=0 during BURST SHALL abort: no further beats, return to IDLE, busy_p=0 next cycle, no burst_done_p.
REQ-019 Both ports writing the same address on one edge: port 0 data SHALL win; collision pulses 1 cycle.
REQ-020 One port writing and other reading the same address on one edge: reader SHALL get old data; collision pulses 1 cycle.
REQ-021 Same-port access SHALL be read-first; two reads of the same address SHALL NOT flag collision.
REQ-022 BIST: bist_start=1 with busy_0=busy_1=0 -> BIST FSM IDLE->WRITE; both busy_p=1 until DONE; port inputs ignored; bist_start while busy ignored.
REQ-023 WRITE: edges 1..DEPTH write mem[a] = (a+1) mod 2**DATA_W, a=0..DEPTH-1.
REQ-024 READ: edges DEPTH+1..2*DEPTH read a=0..DEPTH-1; each word compared to expected one cycle later; any mismatch latches fail.
REQ-025 DONE: after edge 2*DEPTH+1, bist_done=1, ram_passed = no mismatch; both held until next bist_start, which clears both.
REQ-026 BIST SHALL leave the pattern in memory; bursts and collisions SHALL NOT occur during BIST.

Reset
REQ-027 rst=1 SHALL immediately force data_out_p=0, busy_p=0, burst_done_p=0, collision=0, bist_done=0, ram_passed=0, all FSMs IDLE.
REQ-028 Reset mid-burst or mid-BIST SHALL abort it; memory contents SHALL NOT be cleared by reset.

Verification (DATA_W=8, ADDR_W=4)
REQ-029 Port 0 write burst len=16 from addr 0, data 1..16; port 1 read burst len=16 from 0 -> data_out_1 = 1..16 on consecutive cycles, burst_done_1 pulses once.
REQ-030 Read burst len=4 from addr 14 -> addresses 14,15,0,1 returned; busy_1 high 3 cycles.
REQ-031 Both ports write addr 5 same edge (0x11 vs 0x22) -> mem[5]=0x11, collision=1 one cycle; port 1 reads 5 while port 0 writes 0x33 -> old 0x11 returned.
REQ-032 bist_start pulse -> bist_done=1 after edge 33, ram_passed=1, mem[a]=a+1.
REQ-033 port_en_0 dropped at beat 3 of len-8 write burst -> only beats 0..2 written, no burst_done_0.
REQ-034 rst asserted mid-BIST -> all outputs 0 asynchronously; new bist_start completes with ram_passed=1.

Source files
------------

// File: rtl/dual_port_burst_ram.sv
// Two-port RAM with per-port incrementing bursts, a same-address collision flag
// and a built-in write/read-back self test.
module dual_port_burst_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int BLEN_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              port_en_0,
  input  logic              wr_en_0,
  input  logic              burst_en_0,
  input  logic [BLEN_W-1:0] burst_len_0,
  input  logic [ADDR_W-1:0] addr_in_0,
  input  logic [DATA_W-1:0] data_in_0,
  input  logic              port_en_1,
  input  logic              wr_en_1,
  input  logic              burst_en_1,
  input  logic [BLEN_W-1:0] burst_len_1,
  input  logic [ADDR_W-1:0] addr_in_1,
  input  logic [DATA_W-1:0] data_in_1,
  output logic [DATA_W-1:0] data_out_0,
  output logic              busy_0,
  output logic              burst_done_0,
  output logic [DATA_W-1:0] data_out_1,
  output logic              busy_1,
  output logic              burst_done_1,
  output logic              collision,
  input  logic              bist_start,
  output logic              bist_done,
  output logic              ram_passed
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {P_IDLE, P_BURST} port_state_t;
  typedef enum logic [1:0] {B_IDLE, B_WRITE, B_READ, B_DONE} bist_state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        port_en_v, wr_en_v, burst_en_v;
  logic [BLEN_W-1:0] burst_len_v [2];
  logic [ADDR_W-1:0] addr_in_v [2];
  logic [DATA_W-1:0] data_in_v [2];

  assign port_en_v  = {port_en_1, port_en_0};
  assign wr_en_v    = {wr_en_1, wr_en_0};
  assign burst_en_v = {burst_en_1, burst_en_0};
  assign burst_len_v[0] = burst_len_0;
  assign burst_len_v[1] = burst_len_1;
  assign addr_in_v[0]   = addr_in_0;
  assign addr_in_v[1]   = addr_in_1;
  assign data_in_v[0]   = data_in_0;
  assign data_in_v[1]   = data_in_1;

  logic [1:0]        acc_v, we_v, busy_v, done_v;
  logic [ADDR_W-1:0] acc_addr_v [2];
  logic [DATA_W-1:0] dout_v [2];

  bist_state_t       bist_state_reg;
  logic [ADDR_W:0]   bist_cnt_reg;
  logic              bist_active, bist_go, port_hold;
  logic [DATA_W-1:0] bist_pattern;

  assign bist_active  = (bist_state_reg == B_WRITE) || (bist_state_reg == B_READ);
  assign bist_go      = bist_start && (busy_v == 2'b00);
  // The edge that launches BIST performs no port access either.
  assign port_hold    = bist_active || bist_go;
  assign bist_pattern = DATA_W'(bist_cnt_reg) + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      port_state_t       state_reg;
      logic [ADDR_W-1:0] addr_reg;
      logic [BLEN_W-1:0] rem_reg;
      logic              dir_reg, done_reg;
      logic [DATA_W-1:0] dout_reg;
      logic              acc, we, start;
      logic [ADDR_W-1:0] a;

      always_comb begin
        acc   = 1'b0;
        we    = 1'b0;
        start = 1'b0;
        a     = addr_in_v[gi];
        if (!rst && !port_hold && port_en_v[gi]) begin
          if (state_reg == P_BURST) begin
            acc = 1'b1;
            we  = dir_reg;
            a   = addr_reg;
          end else if (burst_en_v[gi]) begin
            if (burst_len_v[gi] != '0) begin
              acc   = 1'b1;
              we    = wr_en_v[gi];
              start = 1'b1;
            end
          end else begin
            acc = 1'b1;
            we  = wr_en_v[gi];
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg <= P_IDLE;
          addr_reg  <= '0;
          rem_reg   <= '0;
          dir_reg   <= 1'b0;
          done_reg  <= 1'b0;
          dout_reg  <= '0;
        end else begin
          done_reg <= 1'b0;
          if (acc && !we) dout_reg <= mem[a];
          case (state_reg)
            P_IDLE: begin
              if (start) begin
                if (burst_len_v[gi] == BLEN_W'(1)) begin
                  done_reg <= 1'b1;
                end else begin
                  state_reg <= P_BURST;
                  addr_reg  <= a + 1'b1;
                  rem_reg   <= burst_len_v[gi] - 1'b1;
                  dir_reg   <= wr_en_v[gi];
                end
              end
            end
            default: begin
              // rem_reg counts beats still to go, including this edge's beat.
              if (!port_en_v[gi]) begin
                state_reg <= P_IDLE;
              end else begin
                addr_reg <= addr_reg + 1'b1;
                rem_reg  <= rem_reg - 1'b1;
                if (rem_reg == BLEN_W'(1)) begin
                  state_reg <= P_IDLE;
                  done_reg  <= 1'b1;
                end
              end
            end
          endcase
        end
      end

      assign acc_v[gi]      = acc;
      assign we_v[gi]       = acc && we;
      assign acc_addr_v[gi] = a;
      assign busy_v[gi]     = (state_reg == P_BURST) || bist_active;
      assign done_v[gi]     = done_reg;
      assign dout_v[gi]     = dout_reg;
    end
  endgenerate

  // Port 0 is written last so it wins a same-address write race.
  always_ff @(posedge clk) begin
    if (!rst && bist_state_reg == B_WRITE) begin
      mem[bist_cnt_reg[ADDR_W-1:0]] <= bist_pattern;
    end else begin
      if (we_v[1]) mem[acc_addr_v[1]] <= data_in_v[1];
      if (we_v[0]) mem[acc_addr_v[0]] <= data_in_v[0];
    end
  end

  logic              collision_reg, bist_done_reg, ram_passed_reg, fail_reg;
  logic              rd_valid_reg, rd_bad;
  logic [DATA_W-1:0] rd_data_reg, rd_exp_reg;

  assign rd_bad = rd_valid_reg && (rd_data_reg != rd_exp_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      collision_reg  <= 1'b0;
      bist_state_reg <= B_IDLE;
      bist_cnt_reg   <= '0;
      bist_done_reg  <= 1'b0;
      ram_passed_reg <= 1'b0;
      fail_reg       <= 1'b0;
      rd_valid_reg   <= 1'b0;
      rd_data_reg    <= '0;
      rd_exp_reg     <= '0;
    end else begin
      collision_reg <= (acc_v == 2'b11) && (we_v != 2'b00) && (acc_addr_v[0] == acc_addr_v[1]);
      case (bist_state_reg)
        B_WRITE: begin
          bist_cnt_reg <= bist_cnt_reg + 1'b1;
          if (bist_cnt_reg[ADDR_W-1:0] == '1) begin
            bist_state_reg <= B_READ;
            bist_cnt_reg   <= '0;
          end
        end
        B_READ: begin
          // Reads are checked one cycle later; the extra count step drains the last compare.
          if (rd_bad) fail_reg <= 1'b1;
          if (bist_cnt_reg[ADDR_W]) begin
            rd_valid_reg   <= 1'b0;
            bist_state_reg <= B_DONE;
            bist_done_reg  <= 1'b1;
            ram_passed_reg <= !(fail_reg || rd_bad);
          end else begin
            rd_valid_reg <= 1'b1;
            rd_data_reg  <= mem[bist_cnt_reg[ADDR_W-1:0]];
            rd_exp_reg   <= bist_pattern;
            bist_cnt_reg <= bist_cnt_reg + 1'b1;
          end
        end
        default: begin
          if (bist_go) begin
            bist_state_reg <= B_WRITE;
            bist_cnt_reg   <= '0;
            bist_done_reg  <= 1'b0;
            ram_passed_reg <= 1'b0;
            fail_reg       <= 1'b0;
          end
        end
      endcase
    end
  end

  assign data_out_0   = dout_v[0];
  assign data_out_1   = dout_v[1];
  assign busy_0       = busy_v[0];
  assign busy_1       = busy_v[1];
  assign burst_done_0 = done_v[0];
  assign burst_done_1 = done_v[1];
  assign collision    = collision_reg;
  assign bist_done    = bist_done_reg;
  assign ram_passed   = ram_passed_reg;
endmodule

// File: tb/tb_dual_port_burst_ram.sv
// Directed bench for dual_port_burst_ram: bursts, wrap, collisions, abort,
// BIST and asynchronous reset, with hand-computed expectations.
module tb_dual_port_burst_ram;
  logic       clk, rst;
  logic       port_en_0, wr_en_0, burst_en_0, port_en_1, wr_en_1, burst_en_1;
  logic [5:0] burst_len_0, burst_len_1;
  logic [3:0] addr_in_0, addr_in_1;
  logic [7:0] data_in_0, data_in_1, data_out_0, data_out_1;
  logic       busy_0, busy_1, burst_done_0, burst_done_1;
  logic       collision, bist_start, bist_done, ram_passed;

  int tests = 0;
  int fails = 0;

  dual_port_burst_ram #(.DATA_W(8), .ADDR_W(4), .BLEN_W(6)) dut (
    .clk(clk), .rst(rst),
    .port_en_0(port_en_0), .wr_en_0(wr_en_0), .burst_en_0(burst_en_0),
    .burst_len_0(burst_len_0), .addr_in_0(addr_in_0), .data_in_0(data_in_0),
    .port_en_1(port_en_1), .wr_en_1(wr_en_1), .burst_en_1(burst_en_1),
    .burst_len_1(burst_len_1), .addr_in_1(addr_in_1), .data_in_1(data_in_1),
    .data_out_0(data_out_0), .busy_0(busy_0), .burst_done_0(burst_done_0),
    .data_out_1(data_out_1), .busy_1(busy_1), .burst_done_1(burst_done_1),
    .collision(collision), .bist_start(bist_start), .bist_done(bist_done),
    .ram_passed(ram_passed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    port_en_0 = 0; wr_en_0 = 0; burst_en_0 = 0; burst_len_0 = 0; addr_in_0 = 0; data_in_0 = 0;
    port_en_1 = 0; wr_en_1 = 0; burst_en_1 = 0; burst_len_1 = 0; addr_in_1 = 0; data_in_1 = 0;
    bist_start = 0;
  endtask

  task automatic read1(input logic [3:0] addr, input logic [7:0] exp);
    idle_inputs();
    port_en_1 = 1; addr_in_1 = addr;
    step();
    tests++;
    if (data_out_1 !== exp) begin
      fails++; $display("FAIL read1[%0d]: got %0h expected %0h", addr, data_out_1, exp);
    end
    $display("[TB] p1 read addr=%0d data=%0h", addr, data_out_1);
    idle_inputs();
  endtask

  task automatic test_reset;
    logic [7:0] outs;
    outs = {data_out_0 != 0, data_out_1 != 0, busy_0, busy_1, burst_done_0, burst_done_1, collision, bist_done | ram_passed};
    tests++;
    if (outs !== 8'h00) begin
      fails++; $display("FAIL reset_state: got flags %b expected 00000000", outs);
    end
    $display("[TB] reset state flags=%b", outs);
  endtask

  task automatic test_burst_write_read;
    idle_inputs();
    port_en_0 = 1; wr_en_0 = 1; burst_en_0 = 1; burst_len_0 = 16; addr_in_0 = 0; data_in_0 = 8'd1;
    step();
    tests++;
    if (busy_0 !== 1'b1) begin
      fails++; $display("FAIL wr_burst_busy: got %b expected 1", busy_0);
    end
    for (int k = 1; k < 16; k++) begin
      data_in_0 = 8'(k + 1); addr_in_0 = 4'hF; burst_en_0 = 0; wr_en_0 = 0; burst_len_0 = 1;
      step();
      tests++;
      if (burst_done_0 !== (k == 15) || busy_0 !== (k != 15)) begin
        fails++; $display("FAIL wr_burst_beat%0d: got done=%b busy=%b expected done=%b busy=%b",
                          k, burst_done_0, busy_0, k == 15, k != 15);
      end
    end
    $display("[TB] p0 write burst len=16 addr=0 done");
    idle_inputs();
    port_en_1 = 1; burst_en_1 = 1; burst_len_1 = 16; addr_in_1 = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (k == 0) begin burst_en_1 = 0; addr_in_1 = 4'h7; wr_en_1 = 1; end
      tests++;
      if (data_out_1 !== 8'(k + 1) || burst_done_1 !== (k == 15)) begin
        fails++; $display("FAIL rd_burst_beat%0d: got data=%0h done=%b expected data=%0h done=%b",
                          k, data_out_1, burst_done_1, k + 1, k == 15);
      end
      $display("[TB] p1 read burst beat %0d data=%0h", k, data_out_1);
    end
    idle_inputs();
    step();
    tests++;
    if (data_out_1 !== 8'h10 || burst_done_1 !== 1'b0) begin
      fails++; $display("FAIL hold_after_burst: got data=%0h done=%b expected data=10 done=0", data_out_1, burst_done_1);
    end
  endtask

  task automatic test_wrap;
    logic [7:0] exp_d [4];
    exp_d[0] = 8'd15; exp_d[1] = 8'd16; exp_d[2] = 8'd1; exp_d[3] = 8'd2;
    idle_inputs();
    port_en_1 = 1; burst_en_1 = 1; burst_len_1 = 4; addr_in_1 = 14;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 0) begin burst_en_1 = 0; addr_in_1 = 0; end
      tests++;
      if (data_out_1 !== exp_d[k] || busy_1 !== (k < 3) || burst_done_1 !== (k == 3)) begin
        fails++; $display("FAIL wrap_beat%0d: got data=%0h busy=%b done=%b expected data=%0h busy=%b done=%b",
                          k, data_out_1, busy_1, burst_done_1, exp_d[k], k < 3, k == 3);
      end
      $display("[TB] p1 wrap burst beat %0d data=%0h", k, data_out_1);
    end
    idle_inputs();
  endtask

  task automatic test_collision;
    idle_inputs();
    port_en_0 = 1; wr_en_0 = 1; addr_in_0 = 5; data_in_0 = 8'h11;
    port_en_1 = 1; wr_en_1 = 1; addr_in_1 = 5; data_in_1 = 8'h22;
    step();
    tests++;
    if (collision !== 1'b1) begin
      fails++; $display("FAIL coll_ww: got %b expected 1", collision);
    end
    idle_inputs();
    step();
    tests++;
    if (collision !== 1'b0) begin
      fails++; $display("FAIL coll_pulse: got %b expected 0", collision);
    end
    port_en_0 = 1; wr_en_0 = 1; addr_in_0 = 5; data_in_0 = 8'h33;
    port_en_1 = 1; addr_in_1 = 5;
    step();
    tests++;
    if (data_out_1 !== 8'h11 || collision !== 1'b1) begin
      fails++; $display("FAIL coll_wr: got data=%0h coll=%b expected data=11 coll=1", data_out_1, collision);
    end
    $display("[TB] collision write/read old data=%0h", data_out_1);
    idle_inputs();
    port_en_0 = 1; addr_in_0 = 5; port_en_1 = 1; addr_in_1 = 5;
    step();
    tests++;
    if (data_out_0 !== 8'h33 || data_out_1 !== 8'h33 || collision !== 1'b0) begin
      fails++; $display("FAIL coll_rr: got d0=%0h d1=%0h coll=%b expected d0=33 d1=33 coll=0",
                        data_out_0, data_out_1, collision);
    end
    idle_inputs();
  endtask

  task automatic test_abort;
    idle_inputs();
    port_en_0 = 1; wr_en_0 = 1; burst_en_0 = 1; burst_len_0 = 8; addr_in_0 = 8; data_in_0 = 8'hA0;
    step();
    burst_en_0 = 0; data_in_0 = 8'hA1; step();
    data_in_0 = 8'hA2; step();
    port_en_0 = 0; data_in_0 = 8'hA3; step();
    tests++;
    if (busy_0 !== 1'b0 || burst_done_0 !== 1'b0) begin
      fails++; $display("FAIL abort_state: got busy=%b done=%b expected 0 0", busy_0, burst_done_0);
    end
    port_en_0 = 1; data_in_0 = 8'hA4; wr_en_0 = 0; addr_in_0 = 0;
    step();
    tests++;
    if (burst_done_0 !== 1'b0 || busy_0 !== 1'b0) begin
      fails++; $display("FAIL abort_no_resume: got busy=%b done=%b expected 0 0", busy_0, burst_done_0);
    end
    $display("[TB] p0 write burst aborted at beat 3");
    read1(8, 8'hA0);
    read1(9, 8'hA1);
    read1(10, 8'hA2);
    read1(11, 8'd12);
    read1(12, 8'd13);
  endtask

  task automatic test_short_lengths;
    idle_inputs();
    port_en_0 = 1; wr_en_0 = 1; burst_en_0 = 1; burst_len_0 = 1; addr_in_0 = 3; data_in_0 = 8'h5A;
    step();
    tests++;
    if (burst_done_0 !== 1'b1 || busy_0 !== 1'b0) begin
      fails++; $display("FAIL len1: got done=%b busy=%b expected 1 0", burst_done_0, busy_0);
    end
    burst_len_0 = 0; addr_in_0 = 4; data_in_0 = 8'hEE;
    step();
    tests++;
    if (burst_done_0 !== 1'b0 || busy_0 !== 1'b0) begin
      fails++; $display("FAIL len0: got done=%b busy=%b expected 0 0", burst_done_0, busy_0);
    end
    $display("[TB] p0 len=1 and len=0 bursts");
    read1(3, 8'h5A);
    read1(4, 8'd5);
  endtask

  task automatic test_bist;
    int n;
    idle_inputs();
    bist_start = 1;
    step();
    bist_start = 0;
    tests++;
    if (busy_0 !== 1'b1 || busy_1 !== 1'b1 || bist_done !== 1'b0) begin
      fails++; $display("FAIL bist_busy: got busy=%b%b done=%b expected 11 0", busy_1, busy_0, bist_done);
    end
    port_en_0 = 1; wr_en_0 = 1; addr_in_0 = 0; data_in_0 = 8'hFF;
    n = 0;
    while (bist_done !== 1'b1 && n < 100) begin step(); n++; end
    tests++;
    if (n !== 33 || ram_passed !== 1'b1 || busy_0 !== 1'b0) begin
      fails++; $display("FAIL bist_done: got edges=%0d passed=%b busy=%b expected 33 1 0", n, ram_passed, busy_0);
    end
    $display("[TB] bist done after %0d edges passed=%b", n, ram_passed);
    idle_inputs();
    step();
    tests++;
    if (bist_done !== 1'b1 || ram_passed !== 1'b1) begin
      fails++; $display("FAIL bist_hold: got done=%b passed=%b expected 1 1", bist_done, ram_passed);
    end
    for (int a = 0; a < 16; a++) read1(4'(a), 8'(a + 1));
  endtask

  task automatic test_reset_mid_bist;
    int n;
    idle_inputs();
    port_en_0 = 1; addr_in_0 = 9;
    step();
    idle_inputs();
    bist_start = 1;
    step();
    bist_start = 0;
    repeat (10) step();
    #3 rst = 1;
    #1;
    tests++;
    if (data_out_0 !== 8'h00 || data_out_1 !== 8'h00 || busy_0 || busy_1 || bist_done || ram_passed || collision) begin
      fails++; $display("FAIL async_reset: got d0=%0h d1=%0h busy=%b%b bdone=%b pass=%b expected all 0",
                        data_out_0, data_out_1, busy_1, busy_0, bist_done, ram_passed);
    end
    $display("[TB] reset asserted mid-BIST");
    step();
    #2 rst = 0;
    read1(0, 8'd1);
    bist_start = 1;
    step();
    bist_start = 0;
    n = 0;
    while (bist_done !== 1'b1 && n < 100) begin step(); n++; end
    tests++;
    if (n !== 33 || ram_passed !== 1'b1) begin
      fails++; $display("FAIL bist_after_reset: got edges=%0d passed=%b expected 33 1", n, ram_passed);
    end
    $display("[TB] second bist edges=%0d passed=%b", n, ram_passed);
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    repeat (2) step();
    test_reset();
    #2 rst = 0;
    step();
    test_burst_write_read();
    test_wrap();
    test_collision();
    test_abort();
    test_short_lengths();
    test_bist();
    test_reset_mid_bist();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
